// File: rtl/adder_share_arbiter_if.sv
// Request/response bundle between NREQ client blocks and the shared adder arbiter.
// The master side belongs to the clients; the slave side belongs to the arbiter.
interface adder_share_arbiter_if #(
    parameter int M    = 4,
    parameter int NREQ = 4
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]   req_valid;
    logic [NREQ*M-1:0] req_a;
    logic [NREQ*M-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [M-1:0]      rsp_sum;
    logic              rsp_carry;
    logic              busy;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry, busy
    );
endinterface

// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter sharing one M-bit adder between NREQ requesters.
// One operation in flight: IDLE (grant) -> EXEC (add) -> RESP (hold result until taken).
module adder_share_arbiter #(
    parameter int M    = 4,
    parameter int NREQ = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    adder_share_arbiter_if.slave bus
);
    localparam int IDW = $clog2(NREQ);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e         state_q;
    logic [IDW-1:0] rr_ptr_q;
    logic [IDW-1:0] rr_ptr_d;
    logic [IDW-1:0] op_id_q;
    logic [M-1:0]   op_a_q;
    logic [M-1:0]   op_b_q;
    logic           rsp_valid_q;
    logic [IDW-1:0] rsp_id_q;
    logic [M-1:0]   rsp_sum_q;
    logic           rsp_carry_q;

    logic [NREQ-1:0] upper_mask_s;
    logic [NREQ-1:0] upper_req_s;
    logic [IDW-1:0]  grant_s;
    logic [NREQ-1:0] req_ready_s;
    logic [M-1:0]    sel_a_s;
    logic [M-1:0]    sel_b_s;
    logic [M:0]      add_s;

    function automatic logic [IDW-1:0] lowest_set(input logic [NREQ-1:0] v);
        logic [IDW-1:0] idx;
        idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (v[i]) idx = IDW'(i);
        end
        return idx;
    endfunction

    function automatic logic [M-1:0] pick_operand(input logic [NREQ*M-1:0] vec,
                                                  input logic [IDW-1:0]    sel);
        logic [M-1:0] r;
        r = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (IDW'(i) == sel) r = vec[i*M +: M];
        end
        return r;
    endfunction

    // Requests at or above the pointer win first; otherwise wrap to the lowest set bit.
    assign upper_mask_s = ~((NREQ'(1) << rr_ptr_q) - NREQ'(1));
    assign upper_req_s  = bus.req_valid & upper_mask_s;
    assign grant_s      = (|upper_req_s) ? lowest_set(upper_req_s) : lowest_set(bus.req_valid);

    // Accept pulse is combinational so the handshake completes in the IDLE cycle itself.
    assign req_ready_s = (rst_n && (state_q == IDLE)) ? ((NREQ'(1) << grant_s) & bus.req_valid)
                                                      : '0;

    assign sel_a_s  = pick_operand(bus.req_a, grant_s);
    assign sel_b_s  = pick_operand(bus.req_b, grant_s);
    assign add_s    = {1'b0, op_a_q} + {1'b0, op_b_q};
    assign rr_ptr_d = (op_id_q == IDW'(NREQ - 1)) ? '0 : (op_id_q + IDW'(1));

    // Arbitration FSM with operand capture and registered response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            op_id_q     <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
            rsp_carry_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|bus.req_valid) begin
                        op_a_q  <= sel_a_s;
                        op_b_q  <= sel_b_s;
                        op_id_q <= grant_s;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_sum_q   <= add_s[M-1:0];
                    rsp_carry_q <= add_s[M];
                    rsp_id_q    <= op_id_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rr_ptr_q    <= rr_ptr_d;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_s;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_sum   = rsp_sum_q;
    assign bus.rsp_carry = rsp_carry_q;
    assign bus.busy      = (state_q != IDLE);

endmodule
